vdp_sprite_line_scheduler: RTL and testbench



---
 rtl/vdp_sprite_pkg.sv | 19 +
 rtl/vdp_sprite_clear_behind.sv | 39 +++
 rtl/vdp_sprite_line_scheduler.sv | 123 ++++++++++++
 tb/tb_vdp_sprite_line_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vdp_sprite_pkg
// Brief    : Shared scheduler state encoding and default raster geometry.
// Revision : 1.0 - initial release
// ============================================================================
package vdp_sprite_pkg;

    localparam int c_lines_total_default = 525;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESTART   = 2'd1,
        ST_RENDERING = 2'd2,
        ST_DONE      = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/vdp_sprite_clear_behind.sv
`default_nettype none
// ============================================================================
// Module   : vdp_sprite_clear_behind
// Brief    : One-cycle register stage turning front-buffer reads into zero writes.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_sprite_clear_behind (
    input  logic       clk,
    input  logic       reset,
    input  logic       scanout_valid,
    input  logic [9:0] scanout_address,
    input  logic       front_buffer,
    output logic       clear_we,
    output logic [9:0] clear_address,
    output logic       clear_buffer
);

    logic       r_we;
    logic [9:0] r_address;
    logic       r_buffer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we      <= 1'b0;
            r_address <= 10'd0;
            r_buffer  <= 1'b0;
        end else begin
            r_we      <= scanout_valid;
            r_address <= scanout_address;
            r_buffer  <= front_buffer;
        end
    end

    assign clear_we      = r_we;
    assign clear_address = r_address;
    assign clear_buffer  = r_buffer;

endmodule
`default_nettype wire

// File: rtl/vdp_sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vdp_sprite_line_scheduler
// Brief    : Per-line sprite renderer sequencer with double-buffer swap and
//            clear-behind; VDP_SPRITE_OVERRUN_COUNT_EN enables the overrun counter.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_sprite_line_scheduler
    import vdp_sprite_pkg::*;
#(
    parameter int LINES_TOTAL     = c_lines_total_default,
    parameter bit ENABLE_ON_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        render_enable,
    input  logic        line_start,
    input  logic [9:0]  raster_line,
    input  logic        render_finished,
    input  logic        scanout_valid,
    input  logic [9:0]  scanout_address,
    output logic        render_restart,
    output logic [9:0]  render_target_line,
    output logic        buffer_select,
    output logic        render_busy,
    output logic        clear_we,
    output logic [9:0]  clear_address,
    output logic        clear_buffer,
    output logic [15:0] overrun_count
);

    localparam logic [10:0] c_lines_total = 11'(LINES_TOTAL);

    sched_state_t r_state;
    sched_state_t w_state_next;
    logic         r_first;
    logic         r_enable;
    logic         r_buffer_select;
    logic [9:0]   r_target;
    logic [10:0]  w_line_inc;
    logic         w_swap;

    // Widened so raster_line values at or beyond the vertical total also wrap.
    assign w_line_inc = {1'b0, raster_line} + 11'd1;
    assign w_swap     = render_enable && line_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_first  <= 1'b0;
            r_enable <= ENABLE_ON_RESET;
        end else begin
            r_state  <= w_state_next;
            r_first  <= (r_state == ST_RESTART);
            r_enable <= render_enable;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buffer_select <= 1'b0;
            r_target        <= 10'd0;
        end else if (w_swap) begin
            r_buffer_select <= !r_buffer_select;
            r_target        <= (w_line_inc >= c_lines_total) ? 10'd0 : w_line_inc[9:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!render_enable) begin
            w_state_next = ST_IDLE;
        end else if (line_start) begin
            w_state_next = ST_RESTART;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_next = ST_IDLE;
                ST_RESTART:   w_state_next = ST_RENDERING;
                // The finished flag seen right after a restart belongs to the previous line.
                ST_RENDERING: w_state_next = (render_finished && !r_first) ? ST_DONE : ST_RENDERING;
                ST_DONE:      w_state_next = ST_DONE;
                default:      w_state_next = ST_IDLE;
            endcase
        end
    end

    assign render_restart     = (r_state == ST_IDLE) || (r_state == ST_RESTART) || !r_enable;
    assign render_busy        = (r_state == ST_RENDERING);
    assign render_target_line = r_target;
    assign buffer_select      = r_buffer_select;

`ifdef VDP_SPRITE_OVERRUN_COUNT_EN
    logic [15:0] r_overrun_count;
    logic        w_overrun;

    assign w_overrun = w_swap && (r_state == ST_RENDERING) && !render_finished;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun_count <= 16'd0;
        end else if (w_overrun && (r_overrun_count != 16'hFFFF)) begin
            r_overrun_count <= r_overrun_count + 16'd1;
        end
    end

    assign overrun_count = r_overrun_count;
`else
    assign overrun_count = 16'd0;
`endif

    vdp_sprite_clear_behind u_clear_behind (
        .clk             (clk),
        .reset           (reset),
        .scanout_valid   (scanout_valid),
        .scanout_address (scanout_address),
        .front_buffer    (!r_buffer_select),
        .clear_we        (clear_we),
        .clear_address   (clear_address),
        .clear_buffer    (clear_buffer)
    );

endmodule
`default_nettype wire

// File: tb/tb_vdp_sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_sprite_line_scheduler
// Brief    : Scoreboard bench for the sprite line scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_sprite_line_scheduler;

    typedef struct packed {
        logic       restart;
        logic       busy;
        logic       bsel;
        logic [9:0] target;
    } ctl_t;

    typedef struct packed {
        logic       we;
        logic [9:0] addr;
        logic       buffer;
    } clr_t;

`ifdef VDP_SPRITE_OVERRUN_COUNT_EN
    localparam bit c_ovr_en = 1'b1;
`else
    localparam bit c_ovr_en = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        render_enable;
    logic        line_start;
    logic [9:0]  raster_line;
    logic        render_finished;
    logic        scanout_valid;
    logic [9:0]  scanout_address;
    logic        render_restart;
    logic [9:0]  render_target_line;
    logic        buffer_select;
    logic        render_busy;
    logic        clear_we;
    logic [9:0]  clear_address;
    logic        clear_buffer;
    logic [15:0] overrun_count;

    ctl_t act_c;
    clr_t act_k;
    ctl_t exp_c;
    clr_t exp_k;
    ctl_t ctl_q[$];
    clr_t clr_q[$];

    int   total;
    int   bad;
    logic       m_bsel;
    logic [9:0] m_target;

    assign act_c = {render_restart, render_busy, buffer_select, render_target_line};
    assign act_k = {clear_we, clear_address, clear_buffer};

    vdp_sprite_line_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .render_enable      (render_enable),
        .line_start         (line_start),
        .raster_line        (raster_line),
        .render_finished    (render_finished),
        .scanout_valid      (scanout_valid),
        .scanout_address    (scanout_address),
        .render_restart     (render_restart),
        .render_target_line (render_target_line),
        .buffer_select      (buffer_select),
        .render_busy        (render_busy),
        .clear_we           (clear_we),
        .clear_address      (clear_address),
        .clear_buffer       (clear_buffer),
        .overrun_count      (overrun_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] next_target(int line);
        return (line + 1 >= 525) ? 10'd0 : 10'(line + 1);
    endfunction

    function automatic ctl_t mk(logic restart, logic busy);
        return {restart, busy, m_bsel, m_target};
    endfunction

    task automatic start_line(int line);
        line_start  = 1'b1;
        raster_line = 10'(line);
        m_bsel      = ~m_bsel;
        m_target    = next_target(line);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset  = 1'b0;
        m_bsel = 1'b0;
        m_target = 10'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        m_bsel = 1'b0;
        m_target = 10'd0;
        ctl_q.push_back(mk(1'b1, 1'b0));
        clr_q.push_back('0);
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL reset_ctl: got %h want %h", act_c, exp_c); end
        exp_k = clr_q.pop_front(); total++;
        if (act_k !== exp_k) begin bad++; $display("FAIL reset_clear: got %h want %h", act_k, exp_k); end
        total++;
        if (overrun_count !== 16'd0) begin bad++; $display("FAIL reset_overrun: got %0d want 0", overrun_count); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_start();
        render_enable = 1'b1;
        start_line(10);
        ctl_q.push_back(mk(1'b1, 1'b0));
        step();
        line_start = 1'b0;
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL start_restart: got %h want %h", act_c, exp_c); end
        ctl_q.push_back(mk(1'b0, 1'b1));
        step();
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL start_rendering: got %h want %h", act_c, exp_c); end
    endtask

    task automatic test_wrap();
        int lines[4] = '{524, 600, 523, 1023};
        for (int i = 0; i < 4; i++) begin
            start_line(lines[i]);
            ctl_q.push_back(mk(1'b1, 1'b0));
            step();
            line_start = 1'b0;
            exp_c = ctl_q.pop_front(); total++;
            if (act_c !== exp_c) begin bad++; $display("FAIL wrap_line%0d: got %h want %h", lines[i], act_c, exp_c); end
            step();
        end
    endtask

    task automatic test_stale_finish();
        render_finished = 1'b1;
        start_line(20);
        ctl_q.push_back(mk(1'b1, 1'b0));
        step();
        line_start = 1'b0;
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL stale_restart: got %h want %h", act_c, exp_c); end
        for (int i = 0; i < 2; i++) begin
            ctl_q.push_back(mk(1'b0, 1'b1));
            step();
            exp_c = ctl_q.pop_front(); total++;
            if (act_c !== exp_c) begin bad++; $display("FAIL stale_masked%0d: got %h want %h", i, act_c, exp_c); end
        end
        render_finished = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ctl_q.push_back(mk(1'b0, 1'b1));
            step();
            exp_c = ctl_q.pop_front(); total++;
            if (act_c !== exp_c) begin bad++; $display("FAIL stale_busy%0d: got %h want %h", i, act_c, exp_c); end
        end
        render_finished = 1'b1;
        ctl_q.push_back(mk(1'b0, 1'b0));
        step();
        render_finished = 1'b0;
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL finish_done: got %h want %h", act_c, exp_c); end
        ctl_q.push_back(mk(1'b0, 1'b0));
        step();
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL done_hold: got %h want %h", act_c, exp_c); end
    endtask

    task automatic test_overrun();
        logic [15:0] exp_ovr;
        pulse_reset();
        render_finished = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_line(100 + i);
            ctl_q.push_back(mk(1'b1, 1'b0));
            step();
            line_start = 1'b0;
            exp_c = ctl_q.pop_front(); total++;
            if (act_c !== exp_c) begin bad++; $display("FAIL overrun_line%0d: got %h want %h", i, act_c, exp_c); end
            repeat (4) step();
        end
        exp_ovr = c_ovr_en ? 16'd3 : 16'd0;
        total++;
        if (overrun_count !== exp_ovr) begin bad++; $display("FAIL overrun_count: got %0d want %0d", overrun_count, exp_ovr); end
        render_finished = 1'b1;
        start_line(104);
        step();
        line_start = 1'b0;
        render_finished = 1'b0;
        total++;
        if (overrun_count !== exp_ovr) begin bad++; $display("FAIL overrun_coincide: got %0d want %0d", overrun_count, exp_ovr); end
        step();
    endtask

    task automatic test_clear_behind();
        pulse_reset();
        scanout_valid   = 1'b1;
        scanout_address = 10'd847;
        start_line(0);
        clr_q.push_back({1'b1, 10'd847, 1'b1});
        ctl_q.push_back(mk(1'b1, 1'b0));
        step();
        line_start = 1'b0;
        exp_k = clr_q.pop_front(); total++;
        if (act_k !== exp_k) begin bad++; $display("FAIL clear_swap: got %h want %h", act_k, exp_k); end
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL clear_swap_ctl: got %h want %h", act_c, exp_c); end
        scanout_address = 10'd5;
        clr_q.push_back({1'b1, 10'd5, ~m_bsel});
        step();
        exp_k = clr_q.pop_front(); total++;
        if (act_k !== exp_k) begin bad++; $display("FAIL clear_after: got %h want %h", act_k, exp_k); end
        scanout_valid   = 1'b0;
        scanout_address = 10'd9;
        clr_q.push_back({1'b0, 10'd9, ~m_bsel});
        step();
        exp_k = clr_q.pop_front(); total++;
        if (act_k !== exp_k) begin bad++; $display("FAIL clear_idle: got %h want %h", act_k, exp_k); end
    endtask

    task automatic test_disable();
        ctl_q.push_back(mk(1'b0, 1'b1));
        step();
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL disable_pre: got %h want %h", act_c, exp_c); end
        render_enable = 1'b0;
        line_start    = 1'b1;
        raster_line   = 10'd50;
        ctl_q.push_back(mk(1'b1, 1'b0));
        step();
        line_start = 1'b0;
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL disable_idle: got %h want %h", act_c, exp_c); end
        render_enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ctl_q.push_back(mk(1'b1, 1'b0));
            step();
            exp_c = ctl_q.pop_front(); total++;
            if (act_c !== exp_c) begin bad++; $display("FAIL disable_stays%0d: got %h want %h", i, act_c, exp_c); end
        end
    endtask

    task automatic test_back_to_back();
        start_line(30);
        ctl_q.push_back(mk(1'b1, 1'b0));
        step();
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL b2b_first: got %h want %h", act_c, exp_c); end
        start_line(31);
        ctl_q.push_back(mk(1'b1, 1'b0));
        step();
        line_start = 1'b0;
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL b2b_second: got %h want %h", act_c, exp_c); end
        ctl_q.push_back(mk(1'b0, 1'b1));
        step();
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL b2b_render: got %h want %h", act_c, exp_c); end
        total++;
        if (overrun_count !== 16'd0) begin bad++; $display("FAIL b2b_overrun: got %0d want 0", overrun_count); end
    endtask

    task automatic test_async_reset();
        scanout_valid = 1'b1;
        step();
        @(posedge clk);
        #3;
        line_start = 1'b1;
        reset      = 1'b1;
        #1;
        m_bsel   = 1'b0;
        m_target = 10'd0;
        ctl_q.push_back(mk(1'b1, 1'b0));
        clr_q.push_back('0);
        exp_c = ctl_q.pop_front(); total++;
        if (act_c !== exp_c) begin bad++; $display("FAIL async_ctl: got %h want %h", act_c, exp_c); end
        exp_k = clr_q.pop_front(); total++;
        if (act_k !== exp_k) begin bad++; $display("FAIL async_clear: got %h want %h", act_k, exp_k); end
        total++;
        if (overrun_count !== 16'd0) begin bad++; $display("FAIL async_overrun: got %0d want 0", overrun_count); end
        line_start    = 1'b0;
        scanout_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        m_bsel          = 1'b0;
        m_target        = 10'd0;
        reset           = 1'b1;
        render_enable   = 1'b0;
        line_start      = 1'b0;
        raster_line     = 10'd0;
        render_finished = 1'b0;
        scanout_valid   = 1'b0;
        scanout_address = 10'd0;

        test_reset();
        test_start();
        test_wrap();
        test_stale_finish();
        test_overrun();
        test_clear_behind();
        test_disable();
        test_back_to_back();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
